battle_controller: RTL and testbench
====================================

BATTLE_CONTROLLER -- requirements
Module: battle_controller

Interface
REQ-001 Parameter NUM_COLS, default 5, number of board columns on the LED matrix.
REQ-002 Parameter NUM_ROWS, default 7, number of board rows (matrix lines).
REQ-003 Parameter MAX_ATTEMPTS, default 10, attack budget per game, 1..15.
REQ-004 clk  in  1  system clock (divided 381 Hz domain).
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 status  in  2  game phase: 00 idle, 01 positioning, 10 attack, 11 hold.
REQ-007 attack_button  in  1  debounced attack level; block does its own edge detection.
REQ-008 col_attack, row_attack  in  3 each  target coordinates, 0-based.
REQ-009 board  in  35  registered ship map; bit c*7+r = ship at column c, row r.
REQ-010 hit_mask, miss_mask  out  35  attacked cells, same bit order as board.
REQ-011 show  out  2  matrix mode: 01 board, 10 hits/misses, 11 end screen.
REQ-012 attempts_left  out  4  remaining attacks; hits_count  out  6  ship cells hit.
REQ-013 win, lose  out  1 each  level, end-of-game result.
REQ-014 dup_pulse, invalid_pulse  out  1 each  one-cycle flags for rejected attacks.

Function
REQ-015 FSM states: IDLE, ARMED, CHECK, UPDATE, WON, LOST; one state register.
REQ-016 IDLE: show=01; status=01 clears both masks, hits_count, sets attempts_left=MAX_ATTEMPTS.
REQ-017 IDLE->ARMED when status=10; on the transition, ship_total := popcount(board) is latched.
REQ-018 ARMED: show=10; a rising edge of attack_button latches col/row and moves to CHECK.
REQ-019 CHECK: col>=NUM_COLS or row>=NUM_ROWS -> invalid_pulse=1, back to ARMED, no attempt consumed.
REQ-020 CHECK: target already in hit_mask or miss_mask -> dup_pulse=1, back to ARMED, no attempt consumed.
REQ-021 CHECK otherwise -> UPDATE; UPDATE sets the hit or miss bit, decrements attempts_left, increments hits_count on hit.
REQ-022 Latency: button edge registered at cycle N, mask/counter update visible at N+3.
REQ-023 After UPDATE: hits_count==ship_total and ship_total!=0 -> WON; else attempts_left==0 -> LOST; else ARMED.
REQ-024 Simultaneous last hit and last attempt: WON takes priority.
REQ-025 WON/LOST: show=11, win/lose held, further button edges ignored; status=01 returns to IDLE with clear.
REQ-026 status leaving 10 in ARMED/CHECK/UPDATE: finish UPDATE if in progress, then go to IDLE; masks retained until status=01.
REQ-027 Button held level produces exactly one attack; a new edge requires release.
REQ-028 ship_total==0 on entry: stay ARMED; game ends only by attempts exhaustion.

Reset
REQ-029 reset_n low, asynchronous: state IDLE, masks 0, hits_count 0, attempts_left=MAX_ATTEMPTS, show=01, all flags 0, edge detector history 0.
REQ-030 Reset deasserted mid-game restarts from IDLE; no partial attack survives.

Configuration
REQ-031 Macro BATTLE_ATTEMPT_LIMIT_EN defined: attempt budget enforced, LOST reachable as REQ-023.
REQ-032 Macro undefined: attempts_left fixed at MAX_ATTEMPTS, no decrement, lose tied 0, LOST unreachable.

Structure
REQ-033 Package battle_pkg holds the state enum, status encodings, show encodings, NUM_COLS/NUM_ROWS defaults, board index function.
REQ-034 One sub-module attack_edge_detect: two-flop history, rising-edge one-cycle pulse, async active-low reset.

Verification
REQ-035 Reset, status 01 then 10, board with 3 ships, attack (0,0) ship -> hit bit 0 set, hits_count=1, attempts_left=9 at edge+3.
REQ-036 Attack (0,0) twice -> second gives dup_pulse=1 for one cycle, attempts_left unchanged at 9.
REQ-037 Attack col=5,row=2 -> invalid_pulse=1, masks and attempts unchanged.
REQ-038 10 misses on empty cells -> lose=1, show=11 after tenth; with macro undefined -> lose stays 0, attempts_left=10.
REQ-039 MAX_ATTEMPTS=3, hit all 3 ships with 3 attacks -> win=1, lose=0 (priority).
REQ-040 reset_n pulsed low during CHECK -> next cycle state IDLE, masks 0, show=01.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared types and helpers for the battleship attack controller: FSM states,
// status/show encodings, default board geometry and the cell index mapping.
package battle_pkg;

    localparam int NUM_COLS_DEFAULT = 5;
    localparam int NUM_ROWS_DEFAULT = 7;

    typedef enum logic [1:0] {
        STATUS_IDLE   = 2'b00,
        STATUS_POS    = 2'b01,
        STATUS_ATTACK = 2'b10,
        STATUS_HOLD   = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        SHOW_OFF   = 2'b00,
        SHOW_BOARD = 2'b01,
        SHOW_SHOTS = 2'b10,
        SHOW_END   = 2'b11
    } show_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CHECK,
        ST_UPDATE,
        ST_WON,
        ST_LOST
    } state_e;

    // Cells are stored column-major: all rows of column 0 first.
    function automatic int board_idx(input int col, input int row, input int num_rows);
        return col * num_rows + row;
    endfunction

endpackage

// File: rtl/attack_edge_detect.sv
// Rising-edge detector for the debounced attack button: two-flop history,
// one-cycle pulse while the newest sample is high and the older one low.
module attack_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic level_i,
    output logic pulse_o
);

    logic [1:0] hist_q;

    // NOTE: non-blocking assignment so both history flops sample the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= {hist_q[0], level_i};
        end
    end

    assign pulse_o = hist_q[0] & ~hist_q[1];

endmodule

// File: rtl/battle_controller.sv
// Attack-phase controller: validates targets, tracks hit/miss masks and decides
// win/lose. Define BATTLE_ATTEMPT_LIMIT_EN to enforce the attack budget.
module battle_controller
    import battle_pkg::*;
#(
    parameter int NUM_COLS     = NUM_COLS_DEFAULT,
    parameter int NUM_ROWS     = NUM_ROWS_DEFAULT,
    parameter int MAX_ATTEMPTS = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [1:0]                   status,
    input  logic                         attack_button,
    input  logic [2:0]                   col_attack,
    input  logic [2:0]                   row_attack,
    input  logic [NUM_COLS*NUM_ROWS-1:0] board,
    output logic [NUM_COLS*NUM_ROWS-1:0] hit_mask,
    output logic [NUM_COLS*NUM_ROWS-1:0] miss_mask,
    output logic [1:0]                   show,
    output logic [3:0]                   attempts_left,
    output logic [5:0]                   hits_count,
    output logic                         win,
    output logic                         lose,
    output logic                         dup_pulse,
    output logic                         invalid_pulse
);

    localparam int         CELLS   = NUM_COLS * NUM_ROWS;
    localparam int         IDX_W   = $clog2(CELLS);
    localparam logic [3:0] ATT_MAX = 4'(MAX_ATTEMPTS);

    state_e             state_q;
    show_e              show_q;
    logic [2:0]         col_q, row_q;
    logic [CELLS-1:0]   hit_mask_q, miss_mask_q;
    logic [5:0]         hits_q, ship_total_q;
    logic [3:0]         attempts_q;
    logic               win_q, lose_q, dup_q, invalid_q;
    logic               atk_pulse;

    logic               tgt_oob, tgt_seen, tgt_ship, out_of_attempts;
    logic [IDX_W-1:0]   tgt_idx;
    logic [CELLS-1:0]   hit_mask_d, miss_mask_d;
    logic [5:0]         hits_d;
    logic [3:0]         attempts_d;

    attack_edge_detect u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .level_i (attack_button),
        .pulse_o (atk_pulse)
    );

    // Outcome of the latched target; only committed while in UPDATE.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tgt_oob     = (int'(col_q) >= NUM_COLS) || (int'(row_q) >= NUM_ROWS);
        tgt_idx     = IDX_W'(board_idx(int'(col_q), int'(row_q), NUM_ROWS));
        tgt_ship    = board[tgt_idx];
        tgt_seen    = hit_mask_q[tgt_idx] | miss_mask_q[tgt_idx];
        hit_mask_d  = hit_mask_q;
        miss_mask_d = miss_mask_q;
        hits_d      = hits_q;
        attempts_d  = attempts_q;
        if (tgt_ship) begin
            hit_mask_d[tgt_idx] = 1'b1;
            hits_d              = hits_q + 6'd1;
        end else begin
            miss_mask_d[tgt_idx] = 1'b1;
        end
`ifdef BATTLE_ATTEMPT_LIMIT_EN
        attempts_d = attempts_q - 4'd1;
`endif
    end

`ifdef BATTLE_ATTEMPT_LIMIT_EN
    assign out_of_attempts = (attempts_d == 4'd0);
`else
    assign out_of_attempts = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            show_q       <= SHOW_BOARD;
            col_q        <= '0;
            row_q        <= '0;
            hit_mask_q   <= '0;
            miss_mask_q  <= '0;
            hits_q       <= '0;
            ship_total_q <= '0;
            attempts_q   <= ATT_MAX;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            dup_q        <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            dup_q     <= 1'b0;
            invalid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    show_q <= SHOW_BOARD;
                    if (status == STATUS_POS) begin
                        hit_mask_q  <= '0;
                        miss_mask_q <= '0;
                        hits_q      <= '0;
                        attempts_q  <= ATT_MAX;
                    end else if (status == STATUS_ATTACK) begin
                        ship_total_q <= 6'($countones(board));
                        show_q       <= SHOW_SHOTS;
                        state_q      <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (status != STATUS_ATTACK) begin
                        show_q  <= SHOW_BOARD;
                        state_q <= ST_IDLE;
                    end else if (atk_pulse) begin
                        col_q   <= col_attack;
                        row_q   <= row_attack;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (status != STATUS_ATTACK) begin
                        show_q  <= SHOW_BOARD;
                        state_q <= ST_IDLE;
                    end else if (tgt_oob) begin
                        invalid_q <= 1'b1;
                        state_q   <= ST_ARMED;
                    end else if (tgt_seen) begin
                        dup_q   <= 1'b1;
                        state_q <= ST_ARMED;
                    end else begin
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    hit_mask_q  <= hit_mask_d;
                    miss_mask_q <= miss_mask_d;
                    hits_q      <= hits_d;
                    attempts_q  <= attempts_d;
                    // A win is tested first so a last-shot hit beats budget exhaustion.
                    if (status != STATUS_ATTACK) begin
                        show_q  <= SHOW_BOARD;
                        state_q <= ST_IDLE;
                    end else if (hits_d == ship_total_q && ship_total_q != 6'd0) begin
                        win_q   <= 1'b1;
                        show_q  <= SHOW_END;
                        state_q <= ST_WON;
                    end else if (out_of_attempts) begin
                        lose_q  <= 1'b1;
                        show_q  <= SHOW_END;
                        state_q <= ST_LOST;
                    end else begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_WON, ST_LOST: begin
                    if (status == STATUS_POS) begin
                        hit_mask_q  <= '0;
                        miss_mask_q <= '0;
                        hits_q      <= '0;
                        attempts_q  <= ATT_MAX;
                        win_q       <= 1'b0;
                        lose_q      <= 1'b0;
                        show_q      <= SHOW_BOARD;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hit_mask      = hit_mask_q;
    assign miss_mask     = miss_mask_q;
    assign show          = show_q;
    assign attempts_left = attempts_q;
    assign hits_count    = hits_q;
    assign win           = win_q;
    assign lose          = lose_q;
    assign dup_pulse     = dup_q;
    assign invalid_pulse = invalid_q;

endmodule

// File: tb/tb_battle_controller.sv
// Self-checking bench for battle_controller: directed vector table, corner-case
// sequences and randomized games checked against a cell-array reference model.
`timescale 1ns/1ps
module tb_battle_controller;

    localparam int NC    = 5;
    localparam int NR    = 7;
    localparam int CELLS = NC * NR;
    localparam int MAXA  = 10;
`ifdef BATTLE_ATTEMPT_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       status;
    logic             attack_button;
    logic [2:0]       col_attack, row_attack;
    logic [CELLS-1:0] board;
    logic [CELLS-1:0] hit_mask, miss_mask;
    logic [1:0]       show;
    logic [3:0]       attempts_left;
    logic [5:0]       hits_count;
    logic             win, lose, dup_pulse, invalid_pulse;
    logic [CELLS-1:0] d3_hit_mask, d3_miss_mask;
    logic [1:0]       d3_show;
    logic [3:0]       d3_attempts_left;
    logic [5:0]       d3_hits_count;
    logic             d3_win, d3_lose, d3_dup_pulse, d3_invalid_pulse;

    battle_controller dut (
        .clk(clk), .reset_n(reset_n), .status(status), .attack_button(attack_button),
        .col_attack(col_attack), .row_attack(row_attack), .board(board),
        .hit_mask(hit_mask), .miss_mask(miss_mask), .show(show),
        .attempts_left(attempts_left), .hits_count(hits_count), .win(win), .lose(lose),
        .dup_pulse(dup_pulse), .invalid_pulse(invalid_pulse)
    );

    battle_controller #(.MAX_ATTEMPTS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .status(status), .attack_button(attack_button),
        .col_attack(col_attack), .row_attack(row_attack), .board(board),
        .hit_mask(d3_hit_mask), .miss_mask(d3_miss_mask), .show(d3_show),
        .attempts_left(d3_attempts_left), .hits_count(d3_hits_count), .win(d3_win),
        .lose(d3_lose), .dup_pulse(d3_dup_pulse), .invalid_pulse(d3_invalid_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: per-cell arrays and counters ----------------
    typedef enum {O_INV, O_DUP, O_HIT, O_MISS} outcome_e;
    bit m_ship[NC][NR];
    bit m_shot[NC][NR];
    int m_ships, m_hits, m_used;

    function automatic void model_load(input logic [CELLS-1:0] b);
        m_ships = 0; m_hits = 0; m_used = 0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) begin
                m_ship[c][r] = b[c*NR + r];
                m_shot[c][r] = 1'b0;
                if (m_ship[c][r]) m_ships++;
            end
    endfunction

    function automatic outcome_e model_attack(input int col, input int row);
        if (col >= NC || row >= NR) return O_INV;
        if (m_shot[col][row]) return O_DUP;
        m_shot[col][row] = 1'b1;
        m_used++;
        if (m_ship[col][row]) begin
            m_hits++;
            return O_HIT;
        end
        return O_MISS;
    endfunction

    function automatic bit model_won();
        return (m_ships != 0) && (m_hits == m_ships);
    endfunction

    function automatic bit model_lost();
        return !model_won() && LIMIT && (m_used >= MAXA);
    endfunction

    function automatic logic [CELLS-1:0] model_mask(input bit want_hit);
        logic [CELLS-1:0] m;
        m = '0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                if (m_shot[c][r] && (m_ship[c][r] == want_hit)) m[c*NR + r] = 1'b1;
        return m;
    endfunction

    // ---------------- stimulus helpers ----------------
    logic             s_dup, s_inv, s_q4_flags, s_hold_flags;
    logic [CELLS-1:0] s_pre_hm, s_pre_mm, s_q3_hm, s_q3_mm;

    task automatic new_game(input logic [CELLS-1:0] b);
        @(negedge clk);
        status = 2'b01;
        board  = b;
        @(negedge clk);
        @(negedge clk);
        status = 2'b10;
        @(negedge clk);
        model_load(b);
    endtask

    // Press at Q0; flags sampled at Q3, committed state at Q4 (edge + 3).
    task automatic attack(input int col, input int row, input int hold);
        @(negedge clk);
        col_attack    = 3'(col);
        row_attack    = 3'(row);
        attack_button = 1'b1;
        s_pre_hm      = hit_mask;
        s_pre_mm      = miss_mask;
        repeat (3) @(negedge clk);
        s_dup   = dup_pulse;
        s_inv   = invalid_pulse;
        s_q3_hm = hit_mask;
        s_q3_mm = miss_mask;
        @(negedge clk);
        s_q4_flags   = dup_pulse | invalid_pulse;
        s_hold_flags = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            s_hold_flags = s_hold_flags | dup_pulse | invalid_pulse;
        end
        attack_button = 1'b0;
    endtask

    task automatic check_attack(input string tag, input outcome_e oc);
        bit over;
        over = model_won() || model_lost();
        check({tag, " dup_pulse"}, s_dup, oc == O_DUP);
        check({tag, " invalid_pulse"}, s_inv, oc == O_INV);
        check({tag, " hit_mask early"}, s_q3_hm, s_pre_hm);
        check({tag, " miss_mask early"}, s_q3_mm, s_pre_mm);
        check({tag, " flags one-cycle"}, s_q4_flags, 1'b0);
        check({tag, " hit_mask"}, hit_mask, model_mask(1'b1));
        check({tag, " miss_mask"}, miss_mask, model_mask(1'b0));
        check({tag, " hits_count"}, hits_count, m_hits);
        check({tag, " attempts_left"}, attempts_left, LIMIT ? MAXA - m_used : MAXA);
        check({tag, " win"}, win, model_won());
        check({tag, " lose"}, lose, model_lost());
        check({tag, " show"}, show, over ? 2'b11 : 2'b10);
    endtask

    typedef struct {
        int               col;
        int               row;
        bit               exp_dup;
        bit               exp_inv;
        int               exp_hits;
        int               exp_used;
        logic [CELLS-1:0] exp_hm;
        logic [CELLS-1:0] exp_mm;
    } vec_t;

    vec_t             vecs[8];
    logic [CELLS-1:0] three_ships;
    outcome_e         oc;

    initial begin
        // Ships at (0,0)=bit0, (1,2)=bit9, (4,6)=bit34.
        three_ships = 35'h4_0000_0201;
        vecs[0] = '{0, 0, 1'b0, 1'b0, 1, 1, 35'h1,   35'h0};
        vecs[1] = '{0, 0, 1'b1, 1'b0, 1, 1, 35'h1,   35'h0};
        vecs[2] = '{5, 2, 1'b0, 1'b1, 1, 1, 35'h1,   35'h0};
        vecs[3] = '{2, 3, 1'b0, 1'b0, 1, 2, 35'h1,   35'h2_0000};
        vecs[4] = '{0, 7, 1'b0, 1'b1, 1, 2, 35'h1,   35'h2_0000};
        vecs[5] = '{2, 3, 1'b1, 1'b0, 1, 2, 35'h1,   35'h2_0000};
        vecs[6] = '{1, 2, 1'b0, 1'b0, 2, 3, 35'h201, 35'h2_0000};
        vecs[7] = '{3, 0, 1'b0, 1'b0, 2, 4, 35'h201, 35'h22_0000};

        reset_n       = 1'b0;
        status        = 2'b00;
        attack_button = 1'b0;
        col_attack    = '0;
        row_attack    = '0;
        board         = '0;
        repeat (3) @(negedge clk);
        check("reset show", show, 2'b01);
        check("reset hit_mask", hit_mask, '0);
        check("reset miss_mask", miss_mask, '0);
        check("reset hits_count", hits_count, 0);
        check("reset attempts_left", attempts_left, MAXA);
        check("reset win/lose", {win, lose}, 2'b00);
        check("reset pulses", {dup_pulse, invalid_pulse}, 2'b00);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed vector table on a three-ship board.
        new_game(three_ships);
        check("armed show", show, 2'b10);
        for (int i = 0; i < 8; i++) begin
            attack(vecs[i].col, vecs[i].row, 0);
            check($sformatf("tbl%0d dup_pulse", i), s_dup, vecs[i].exp_dup);
            check($sformatf("tbl%0d invalid_pulse", i), s_inv, vecs[i].exp_inv);
            check($sformatf("tbl%0d hits_count", i), hits_count, vecs[i].exp_hits);
            check($sformatf("tbl%0d attempts_left", i), attempts_left,
                  LIMIT ? MAXA - vecs[i].exp_used : MAXA);
            check($sformatf("tbl%0d hit_mask", i), hit_mask, vecs[i].exp_hm);
            check($sformatf("tbl%0d miss_mask", i), miss_mask, vecs[i].exp_mm);
            check($sformatf("tbl%0d show", i), show, 2'b10);
            check($sformatf("tbl%0d win", i), win, 1'b0);
        end

        // Status leaves attack while UPDATE is in flight: update lands, then idle.
        new_game(35'h201);
        attack(0, 0, 0);
        oc = model_attack(0, 0);
        check_attack("abort pre", oc);
        @(negedge clk);
        col_attack = 3'd1; row_attack = 3'd1; attack_button = 1'b1;
        repeat (3) @(negedge clk);
        status = 2'b00;
        @(negedge clk);
        check("abort miss_mask", miss_mask, 35'h100);
        check("abort hit_mask", hit_mask, 35'h1);
        check("abort show", show, 2'b01);
        check("abort attempts_left", attempts_left, LIMIT ? MAXA - 2 : MAXA);
        attack_button = 1'b0;
        repeat (3) @(negedge clk);
        check("abort retained miss_mask", miss_mask, 35'h100);
        check("abort retained hits_count", hits_count, 1);
        status = 2'b01;
        repeat (2) @(negedge clk);
        check("clear hit_mask", hit_mask, '0);
        check("clear miss_mask", miss_mask, '0);
        check("clear hits_count", hits_count, 0);
        check("clear attempts_left", attempts_left, MAXA);

        // A held button yields exactly one attack.
        new_game(35'h201);
        attack(2, 2, 8);
        oc = model_attack(2, 2);
        check_attack("hold", oc);
        check("hold no extra pulse", s_hold_flags, 1'b0);

        // Ten misses: budget exhausted only when the limit is built in.
        new_game(three_ships);
        for (int i = 0; i < 10; i++) begin
            attack((i < 7) ? 2 : 3, (i < 7) ? i : i - 7, 0);
            oc = model_attack((i < 7) ? 2 : 3, (i < 7) ? i : i - 7);
            check_attack($sformatf("miss%0d", i), oc);
        end

        // Win priority on a 3-attempt instance: last shot is also last hit.
        new_game(three_ships);
        attack(0, 0, 0); oc = model_attack(0, 0); check_attack("prio a0", oc);
        attack(1, 2, 0); oc = model_attack(1, 2); check_attack("prio a1", oc);
        attack(4, 6, 0); oc = model_attack(4, 6); check_attack("prio a2", oc);
        check("prio d3 win", d3_win, 1'b1);
        check("prio d3 lose", d3_lose, 1'b0);
        check("prio d3 show", d3_show, 2'b11);
        check("prio d3 hits_count", d3_hits_count, 3);
        check("prio d3 attempts_left", d3_attempts_left, LIMIT ? 0 : 3);
        attack(2, 2, 0);
        check("after win d3 miss_mask", d3_miss_mask, '0);
        check("after win d3 win", d3_win, 1'b1);
        check("after win miss_mask", miss_mask, '0);
        check("after win win", win, 1'b1);
        check("after win show", show, 2'b11);

        // Randomized games against the model, including a ship-less board.
        for (int g = 0; g < 6; g++) begin
            logic [CELLS-1:0] b;
            int               k, col, row;
            b = '0;
            k = (g == 0) ? 0 : int'($urandom_range(1, 4));
            for (int i = 0; i < k; i++)
                b[$urandom_range(0, 2) * NR + $urandom_range(0, 3)] = 1'b1;
            new_game(b);
            for (int a = 0; a < 14 && !(model_won() || model_lost()); a++) begin
                if ($urandom_range(0, 2) == 0) begin
                    col = int'($urandom_range(0, 2));
                    row = int'($urandom_range(0, 3));
                end else begin
                    col = int'($urandom_range(0, 6));
                    row = int'($urandom_range(0, 7));
                end
                attack(col, row, int'($urandom_range(0, 2)));
                oc = model_attack(col, row);
                check_attack($sformatf("rnd g%0d a%0d (%0d,%0d)", g, a, col, row), oc);
            end
        end

        // Asynchronous reset while a target sits in CHECK.
        new_game(35'h201);
        attack(0, 0, 0);
        oc = model_attack(0, 0);
        check_attack("rst pre", oc);
        @(negedge clk);
        col_attack = 3'd2; row_attack = 3'd2; attack_button = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst hit_mask", hit_mask, '0);
        check("rst miss_mask", miss_mask, '0);
        check("rst show", show, 2'b01);
        check("rst attempts_left", attempts_left, MAXA);
        @(negedge clk);
        attack_button = 1'b0;
        reset_n       = 1'b1;
        repeat (5) @(negedge clk);
        check("rst no partial miss_mask", miss_mask, '0);
        check("rst no partial hits_count", hits_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
